// File: rtl/water_arb_pkg.sv
// Shared definitions for the water-valve arbiter: state encoding and default timing constants.
package water_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StSettle = 2'd2
  } arb_state_e;

  localparam int unsigned MaxHoldDefault   = 8;
  localparam int unsigned SettleCycDefault = 2;

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-one search of a request vector starting at a given index.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] start_i,
  output logic [N-1:0]   onehot_o,
  output logic [IdW-1:0] idx_o,
  output logic           valid_o
);

  logic [IdW-1:0] cand;
  int unsigned    pos;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    pos      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos  = (32'(start_i) + k) % N;
      cand = IdW'(pos);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/water_valve_arbiter.sv
// Round-robin arbiter sharing one mains water valve between N washer controllers.
// Hold-time preemption is built only when WATER_ARB_TIMEOUT_EN is defined.
module water_valve_arbiter
  import water_arb_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned MAX_HOLD   = MaxHoldDefault,
  parameter int unsigned SETTLE_CYC = SettleCycDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power,
  input  logic                 pause,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 valve_open,
  output logic                 preempt,
  output logic                 busy
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0] id_q, id_d;
  logic [IdW-1:0] rr_q, rr_d;
  logic [SetW-1:0] set_q, set_d;
  logic           valve_q, valve_d;
  logic           busy_q, busy_d;
  logic           leave;

  logic [N-1:0]   pick_oh;
  logic [IdW-1:0] pick_idx;
  logic           pick_vld;

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (rr_q),
    .onehot_o(pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef WATER_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  logic [HoldW-1:0] hold_q, hold_d;
  logic             pre_q, pre_d;
  logic             hold_hit, others;
  // Saturated timer keeps the window open so a late competitor still preempts.
  assign hold_hit = (hold_q >= HoldW'(MAX_HOLD - 1));
  assign others   = |(req & ~gnt_q);
  assign preempt  = pre_q;
`else
  assign preempt  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    rr_d    = rr_q;
    set_d   = set_q;
    busy_d  = busy_q;
    leave   = 1'b0;
`ifdef WATER_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    pre_d   = 1'b0;
`endif
    if (!power) begin
      state_d = StIdle;
      gnt_d   = '0;
      id_d    = '0;
      set_d   = '0;
      busy_d  = 1'b0;
`ifdef WATER_ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end else if (!pause) begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            state_d = StGrant;
            gnt_d   = pick_oh;
            id_d    = pick_idx;
            busy_d  = 1'b1;
`ifdef WATER_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end
        StGrant: begin
          leave = !req[id_q];
`ifdef WATER_ARB_TIMEOUT_EN
          // A voluntary release never reports as a preemption.
          if (!leave && hold_hit && others) begin
            leave = 1'b1;
            pre_d = 1'b1;
          end else if (hold_q != HoldW'(MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
          end
`endif
          if (leave) begin
            state_d = StSettle;
            gnt_d   = '0;
            id_d    = '0;
            set_d   = '0;
            rr_d    = (id_q == IdW'(N - 1)) ? '0 : id_q + 1'b1;
          end
        end
        StSettle: begin
          if (set_q == SetW'(SETTLE_CYC - 1)) begin
            state_d = StIdle;
            set_d   = '0;
            busy_d  = 1'b0;
          end else begin
            set_d = set_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          gnt_d   = '0;
          id_d    = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
    valve_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      set_q   <= '0;
      valve_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef WATER_ARB_TIMEOUT_EN
      hold_q  <= '0;
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      set_q   <= set_d;
      valve_q <= valve_d;
      busy_q  <= busy_d;
`ifdef WATER_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      pre_q   <= pre_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = id_q;
  assign valve_open = valve_q;
  assign busy       = busy_q;

endmodule

// File: doc/water_valve_arbiter.md
Name: water_valve_arbiter

Overview:
- Shares one mains water-inlet valve among N washing-machine controllers in a multi-machine laundry installation.
- Each controller raises a request while it needs water (fill or rinse phases). The arbiter grants the valve to one requester at a time using round-robin priority.
- It enforces a maximum hold time and a valve-settle dead time between owners.
- It sits between the per-machine controllers' water_in outputs and the single physical valve driver.

Parameters:
- N, 4, number of requesting machines (2..8).
- MAX_HOLD, 8, grant cycles after which a holder may be preempted if another requester waits (>=2).
- SETTLE_CYC, 2, valve-closed dead cycles between owners (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- power  input  1  mains enable; low forces release.
- pause  input  1  freezes arbiter state, timers and outputs.
- req  input  N  per-machine water request, level-sensitive.
- gnt  output  N  one-hot grant (all zero when no owner), registered.
- gnt_id  output  $clog2(N)  index of current owner; 0 when no owner.
- valve_open  output  1  physical valve drive; equals |gnt.
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout.
- busy  output  1  high in GRANT or SETTLE.

Behaviour:
- Reset values: gnt=0, gnt_id=0, valve_open=0, preempt=0, busy=0, state=IDLE, rr pointer=0, hold timer=0, settle counter=0.
- States: IDLE, GRANT, SETTLE. All outputs are registered.
- IDLE:
  - If power && !pause && |req: select the first set req bit searching cyclically from the rr pointer.
  - Next cycle: state=GRANT, gnt one-hot, gnt_id set, valve_open=1, hold timer=0.
  - Latency is one cycle: req sampled at edge t gives gnt visible after edge t+1.
- GRANT:
  - Hold timer increments each unpaused cycle and saturates at MAX_HOLD.
  - Release: req[owner] sampled low -> next cycle gnt=0, valve_open=0, rr pointer=owner+1 (mod N), go SETTLE.
  - Preempt: timer==MAX_HOLD-1 && req[owner] high && any other req bit high -> next cycle gnt=0, preempt=1 for exactly one cycle, rr pointer=owner+1, go SETTLE.
  - No other requester pending: the owner keeps the grant indefinitely and the timer saturates. Preemption fires on the first later cycle another request appears while timer>=MAX_HOLD-1.
  - Release and preempt conditions true in the same cycle: release wins and preempt stays 0.
- SETTLE:
  - gnt=0, valve_open=0, busy=1 for exactly SETTLE_CYC cycles, then IDLE.
  - Requests arriving during SETTLE are served from IDLE. Minimum owner-to-owner gap is SETTLE_CYC+1 cycles of valve closed.
- pause high: state, timers, rr pointer and all outputs hold their values. preempt is cleared after its single pulse even while paused.
- power low (not paused): next cycle gnt=0, valve_open=0, busy=0, state=IDLE, timers=0. The rr pointer is retained. No preempt pulse. power low takes priority over pause.
- Reset mid-grant: all outputs return to reset values on the next edge, with no settle period.
- rr pointer wraps from N-1 to 0. Requests from an index beyond N do not exist, because req is exactly N bits wide.

Optional Feature:
- WATER_ARB_TIMEOUT_EN defined: MAX_HOLD preemption behaves as above.
- Undefined:
  - The hold timer and the preempt logic are not built, and preempt is tied to 0.
  - The owner keeps the valve until it drops req.
  - Round-robin rotation on release is unchanged.

Decomposition:
- Shared package water_arb_pkg holds the state encoding typedef (IDLE/GRANT/SETTLE) and the default MAX_HOLD/SETTLE_CYC constants, for reuse by the washer controllers and testbench.
- One sub-module, rr_pick: combinational cyclic first-one search of req from a start pointer, returning a one-hot vector and an index.

Test Plan (N=4, MAX_HOLD=8, SETTLE_CYC=2, timeout enabled):
- reset, then req=4'b0100 -> gnt=4'b0100 and gnt_id=2 one cycle later. Drop req -> gnt=0 for 2 settle cycles. rr pointer=3.
- req=4'b1001 with pointer=3 -> gnt=4'b1000. Owner drops req -> settle 2 cycles, then gnt=4'b0001.
- req[1] held continuously plus req[3] raised -> gnt[1] for 8 cycles, preempt=1 for one cycle, 2 closed cycles, then gnt=4'b1000.
- req[0] alone held for 30 cycles -> gnt stays 4'b0001 and preempt never asserts. Raise req[2] at cycle 30 -> preempt on the next cycle.
- pause asserted for 5 cycles mid-GRANT -> gnt is unchanged and the timer is frozen. Preempt occurs 5 cycles later than in the unpaused case.
- power low during GRANT -> gnt=0 and valve_open=0 next cycle, busy=0, no preempt. Power back with the same req -> grant without a settle period.
